// File: rtl/mux_scan_ctrl.sv
// Scans a 4:1 mux through channels 0..3 with a programmable dwell, samples y on
// each channel and offers the packed 4-bit word on a valid/ready handshake.
module mux_scan_ctrl #(
  parameter int DWELL = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cont,
  input  logic       y,
  output logic [1:0] sel,
  output logic [3:0] word,
  output logic       word_valid,
  input  logic       word_ready,
  output logic       busy,
  output logic       overrun
);

  localparam int CW = (DWELL > 2) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DWELL - 1);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    asm, asm_n;
  logic [1:0]    sel_n;
  logic [3:0]    word_n;
  logic          word_valid_n, busy_n, overrun_n;
  logic [3:0]    done_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sel        <= 2'd0;
      cnt        <= '0;
      asm        <= 4'd0;
      word       <= 4'd0;
      word_valid <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_n;
      sel        <= sel_n;
      cnt        <= cnt_n;
      asm        <= asm_n;
      word       <= word_n;
      word_valid <= word_valid_n;
      busy       <= busy_n;
      overrun    <= overrun_n;
    end
  end

  always_comb begin
    state_n      = state;
    sel_n        = sel;
    cnt_n        = cnt;
    asm_n        = asm;
    word_n       = word;
    word_valid_n = word_valid;
    busy_n       = busy;
    overrun_n    = overrun;
    // Channel 3's sample bypasses asm so the word is ready on the final dwell edge.
    done_word    = {y, asm[2:0]};

    if (word_valid && word_ready) word_valid_n = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_n = SCAN;
          sel_n   = 2'd0;
          cnt_n   = CNT_LOAD;
          busy_n  = 1'b1;
        end
      end
      SCAN: begin
        if (cnt != '0) begin
          cnt_n = cnt - CW'(1);
        end else begin
          asm_n[sel] = y;
          if (sel != 2'd3) begin
            sel_n = sel + 2'd1;
            cnt_n = CNT_LOAD;
          end else begin
            // A pending word that is not being accepted this edge wins; the new one is lost.
            if (!word_valid || word_ready) begin
              word_n       = done_word;
              word_valid_n = 1'b1;
            end else begin
              overrun_n = 1'b1;
            end
            sel_n = 2'd0;
            if (cont) begin
              cnt_n = CNT_LOAD;
            end else begin
              state_n = IDLE;
              busy_n  = 1'b0;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: three instances (DWELL 2, 1, 3) sharing stimulus,
// each compared every cycle against a time-based scan model.
module tb_mux_scan_ctrl;
  localparam int N = 3;

  function automatic int dw_of(input int i);
    case (i)
      0: return 2;
      1: return 1;
      default: return 3;
    endcase
  endfunction

  logic       clk = 1'b0;
  logic       rst, start, cont, word_ready;
  logic [3:0] mux_in;

  logic [1:0] sel_w   [N];
  logic       y_w     [N];
  logic [3:0] word_w  [N];
  logic       valid_w [N];
  logic       busy_w  [N];
  logic       ovr_w   [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int D = (g == 0) ? 2 : ((g == 1) ? 1 : 3);
    assign y_w[g] = mux_in[sel_w[g]];
    mux_scan_ctrl #(.DWELL(D)) dut (
      .clk(clk), .rst(rst), .start(start), .cont(cont), .y(y_w[g]),
      .sel(sel_w[g]), .word(word_w[g]), .word_valid(valid_w[g]),
      .word_ready(word_ready), .busy(busy_w[g]), .overrun(ovr_w[g])
    );
  end

  // Model: a scan is a run of 4*dwell edges; t counts edges since it began.
  int         m_t     [N];
  bit         m_busy  [N];
  logic [3:0] m_word  [N];
  logic [3:0] m_samp  [N];
  bit         m_valid [N];
  bit         m_ovr   [N];

  int n_chk = 0, n_pass = 0, n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s[inst %0d] at %0t: got %0h, expected %0h", nm, inst, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      automatic int         dw = dw_of(i);
      automatic int         t  = m_t[i];
      automatic bit         b  = m_busy[i];
      automatic logic [3:0] w  = m_word[i];
      automatic logic [3:0] s  = m_samp[i];
      automatic bit         v  = m_valid[i];
      automatic bit         o  = m_ovr[i];
      automatic bit         nv;
      if (rst) begin
        t = 0; b = 0; w = 4'd0; s = 4'd0; v = 0; o = 0;
      end else begin
        nv = v && !word_ready;
        if (!b) begin
          if (start) begin b = 1; t = 0; end
        end else begin
          if (t % dw == dw - 1) s[t / dw] = mux_in[t / dw];
          t++;
          if (t == 4 * dw) begin
            if (!v || word_ready) begin w = s; nv = 1; end
            else o = 1;
            t = 0;
            if (!cont) b = 0;
          end
        end
        v = nv;
      end
      m_t[i] <= t; m_busy[i] <= b; m_word[i] <= w;
      m_samp[i] <= s; m_valid[i] <= v; m_ovr[i] <= o;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        chk("sel", i, 32'(sel_w[i]), m_busy[i] ? 32'(m_t[i] / dw_of(i)) : 32'd0);
        chk("word", i, 32'(word_w[i]), 32'(m_word[i]));
        chk("word_valid", i, 32'(valid_w[i]), 32'(m_valid[i]));
        chk("busy", i, 32'(busy_w[i]), 32'(m_busy[i]));
        chk("overrun", i, 32'(ovr_w[i]), 32'(m_ovr[i]));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int k;
    cont = 1'b0;
    start = 1'b0;
    k = 0;
    while ((busy_w[0] || busy_w[1] || busy_w[2]) && k < 200) begin
      tick();
      k++;
    end
    if (k >= 200) chk("idle_wait_timeout", 0, 32'd1, 32'd0);
    tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cont = 1'b0; word_ready = 1'b0; mux_in = 4'd0;
    repeat (3) tick();
    rst = 1'b0;
    chk_en = 1'b1;

    // Idle after reset: everything zero.
    for (int e = 0; e < 5; e++) begin
      tick();
      chk("idle_sel", 0, 32'(sel_w[0]), 32'd0);
      chk("idle_out", 0, {word_w[0], valid_w[0], busy_w[0], ovr_w[0]}, 32'd0);
    end

    // Single shot, DWELL=2, a=1 b=0 c=1 d=1.
    mux_in = 4'b1101; word_ready = 1'b1; cont = 1'b0; start = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick();
      if (e == 0) start = 1'b0;
      chk("ss_sel", 0, 32'(sel_w[0]), 32'(e / 2));
      chk("ss_busy", 0, 32'(busy_w[0]), 32'd1);
    end
    tick();
    chk("ss_word", 0, 32'(word_w[0]), 32'hD);
    chk("ss_valid", 0, 32'(valid_w[0]), 32'd1);
    chk("ss_busy_low", 0, 32'(busy_w[0]), 32'd0);
    tick();
    chk("ss_valid_clr", 0, 32'(valid_w[0]), 32'd0);
    wait_idle();

    // Continuous, DWELL=1, y=1, always ready.
    mux_in = 4'hF; cont = 1'b1; word_ready = 1'b1; start = 1'b1;
    for (int e = 0; e <= 12; e++) begin
      tick();
      if (e == 0) start = 1'b0;
      chk("cont_busy", 1, 32'(busy_w[1]), 32'd1);
      chk("cont_ovr", 1, 32'(ovr_w[1]), 32'd0);
      chk("cont_valid", 1, 32'(valid_w[1]), (e > 0 && e % 4 == 0) ? 32'd1 : 32'd0);
      if (e > 0 && e % 4 == 0) chk("cont_word", 1, 32'(word_w[1]), 32'hF);
    end
    wait_idle();

    // Continuous with no ready: second word dropped.
    mux_in = 4'b1010; cont = 1'b1; word_ready = 1'b0; start = 1'b1;
    for (int e = 0; e <= 8; e++) begin
      tick();
      if (e == 0) start = 1'b0;
      if (e == 4) begin
        chk("ovr_first", 1, 32'(word_w[1]), 32'hA);
        mux_in = 4'b0101;
      end
      if (e == 7) chk("ovr_pre", 1, 32'(ovr_w[1]), 32'd0);
      if (e == 8) begin
        chk("ovr_set", 1, 32'(ovr_w[1]), 32'd1);
        chk("ovr_held", 1, 32'(word_w[1]), 32'hA);
        chk("ovr_valid", 1, 32'(valid_w[1]), 32'd1);
      end
    end
    rst = 1'b1; cont = 1'b0;
    tick();
    rst = 1'b0;
    chk("ovr_rst", 1, 32'(ovr_w[1]), 32'd0);
    wait_idle();

    // Ready pulsed exactly on end-of-scan edges.
    mux_in = 4'b0011; cont = 1'b1; word_ready = 1'b0; start = 1'b1;
    for (int e = 0; e <= 12; e++) begin
      tick();
      if (e == 0) start = 1'b0;
      if (e == 4) begin
        chk("b2b_first", 1, 32'(word_w[1]), 32'h3);
        mux_in = 4'b1100;
      end
      if (e == 7 || e == 11) word_ready = 1'b1;
      if (e == 8 || e == 12) begin
        word_ready = 1'b0;
        chk("b2b_word", 1, 32'(word_w[1]), 32'hC);
        chk("b2b_valid", 1, 32'(valid_w[1]), 32'd1);
        chk("b2b_ovr", 1, 32'(ovr_w[1]), 32'd0);
      end
    end
    rst = 1'b1; cont = 1'b0;
    tick();
    rst = 1'b0;
    wait_idle();

    // Reset at edge 3 of a DWELL=2 scan, then a clean scan.
    mux_in = 4'b0110; cont = 1'b0; word_ready = 1'b1; start = 1'b1;
    for (int e = 0; e < 3; e++) begin
      tick();
      if (e == 0) start = 1'b0;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid", 0, {sel_w[0], word_w[0], valid_w[0], busy_w[0], ovr_w[0]}, 32'd0);
    start = 1'b1;
    for (int e = 0; e <= 8; e++) begin
      tick();
      if (e == 0) start = 1'b0;
    end
    chk("rst_rescan_word", 0, 32'(word_w[0]), 32'h6);
    chk("rst_rescan_valid", 0, 32'(valid_w[0]), 32'd1);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      tick();
      start      = ($urandom_range(0, 7) == 0);
      cont       = ($urandom_range(0, 2) == 0);
      word_ready = ($urandom_range(0, 3) != 0);
      rst        = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) mux_in = 4'($urandom);
    end
    rst = 1'b0;
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Channel scanner for the 4:1 mux. It drives the mux select `sel` through channels 0..3 with a programmable dwell per channel and samples the 1-bit mux output `y` on each channel. It packs the four samples into a 4-bit word and offers the word downstream on a valid/ready handshake. It supports single-shot and continuous scanning, and flags words dropped because of downstream backpressure.

## Interface
Parameters:
- `DWELL`, default 2: cycles `sel` is held per channel; legal range 1..16. `y` is sampled on the last dwell cycle.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a scan. Sampled only in IDLE; ignored while busy.
- `cont`  in  1  continuous mode. Sampled at the end of each scan.
- `y`  in  1  mux output; combinational from `sel`.
- `sel`  out  2  mux select. Registered.
- `word`  out  4  scanned word; bit k = `y` sampled while `sel` = k.
- `word_valid`  out  1  `word` is available.
- `word_ready`  in  1  downstream accepts `word`.
- `busy`  out  1  a scan is in progress.
- `overrun`  out  1  sticky; a completed word was dropped.

## Operation
- States: IDLE and SCAN.
- Internal signals:
  - `cnt` is the dwell counter, width clog2(DWELL) with a minimum of 1.
  - `asm` is a 4-bit assembly register.
  - The output register pair (`word`, `word_valid`) is separate from `asm`.
- Reset values: state IDLE, `sel`=0, `cnt`=0, `asm`=0, `word`=0, `word_valid`=0, `busy`=0, `overrun`=0.
- IDLE, with `start`=1 at an edge: go to SCAN, `sel`<=0, `cnt`<=DWELL-1, `busy`<=1.
- SCAN, with `cnt`!=0 at an edge: `cnt`<=`cnt`-1. `sel` is held.
- SCAN, with `cnt`==0 at an edge:
  - Capture: `asm[sel]`<=`y`.
  - If `sel`<3: `sel`<=`sel`+1 and `cnt`<=DWELL-1.
  - If `sel`==3: end of scan. The completed word is {`y`, `asm[2:0]`}, so the current `y` is included directly.
- Word transfer at end of scan:
  - If `word_valid`=0, or `word_valid`=1 with `word_ready`=1 on the same edge: `word`<=completed word and `word_valid`<=1.
  - Otherwise the completed word is dropped, `overrun`<=1, and `word`/`word_valid` are unchanged.
- State after end of scan:
  - If `cont`=1: stay in SCAN with `sel`<=0, `cnt`<=DWELL-1, `busy` stays 1. There is no gap between scans.
  - If `cont`=0: go to IDLE with `sel`<=0 and `busy`<=0.
- Handshake:
  - `word` and `word_valid` are held stable while `word_valid`=1 and `word_ready`=0.
  - An edge with `word_valid`=1 and `word_ready`=1 and no new word clears `word_valid`.
  - `word_ready` while `word_valid`=0 has no effect.
- `overrun` clears only on `rst`.
- `rst` asserted at any point, including mid-scan or with a word pending, returns every register to its reset value on that edge. Partial `asm` content is discarded.
- `start`=1 while in SCAN is ignored. `start`=1 on the same edge that a single-shot scan returns to IDLE is also ignored; it is seen again on the next edge.

## Timing
- Edge 0 is the edge that sees `start`=1 in IDLE.
- `sel`=k is visible in cycles k·DWELL+1 through (k+1)·DWELL.
- `y` for channel k is captured at edge (k+1)·DWELL.
- `word_valid` rises after edge 4·DWELL. With DWELL=2, that is edge 8.
- Continuous mode: one word every 4·DWELL cycles.
- `busy` is high from after edge 0 through edge 4·DWELL. In single-shot mode it is low from the cycle after edge 4·DWELL.
- `sel` changes only on edges; there are no combinational paths from inputs to outputs.
- A downstream consumer must accept a word within 4·DWELL cycles in continuous mode to avoid overrun.

## Test plan
- Reset, then idle for 5 cycles with `start`=0: all outputs stay 0, and `sel` stays 0.
- DWELL=2, single shot, `y` driven as the mux of a=1, b=0, c=1, d=1 (bit 0 of each input), `word_ready`=1: `word`=4'b1101 with `word_valid` high after edge 8, `busy` low from cycle 9, and the `sel` sequence is 0,0,1,1,2,2,3,3.
- DWELL=1, `cont`=1, `word_ready`=1, `y`=1: a word of 4'b1111 every 4 cycles, `busy` constantly 1, `overrun`=0.
- DWELL=1, `cont`=1, `word_ready`=0: the first word is held, `overrun` goes to 1 at edge 8, and `word` still equals the first word.
- Back-to-back scans with `word_ready` pulsed on exactly the end-of-scan edge: the new word loads, `word_valid` stays 1, `overrun`=0.
- `rst` asserted at edge 3 of a DWELL=2 scan: the next cycle shows IDLE with all outputs 0. A following `start` produces a full, correct word.
